// File: rtl/mem_dump_pkg.sv
`timescale 1ns/1ps
// Shared types and character constants for the memory-dump UART sequencer.
package mem_dump_pkg;

   typedef enum logic [2:0] {IDLE, RD, LATCH, SEND, NEXT, FIN} state_t;

   localparam logic [7:0] COLON    = 8'h3A;
   localparam logic [7:0] CR       = 8'h0D;
   localparam logic [7:0] LF       = 8'h0A;
   localparam int         LINE_LEN = 13;

   // Uppercase hex digit for one nibble.
   function automatic logic [7:0] hex2ascii(input logic [3:0] nibble);
      return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
`timescale 1ns/1ps
// 8N1 byte transmitter; each bit lasts CLK_HZ/BAUD clocks, tx idles high.
module uart_tx_byte #(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx
);
   localparam int            DIV      = CLK_HZ / BAUD;
   localparam int            CW       = $clog2(DIV);
   localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

   logic          active;
   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shift;

   assign tx_ready = ~active;

   // The start bit goes out on acceptance; shift holds the data bits then the stop bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '1;
         tx       <= 1'b1;
      end else if (!active) begin
         if (tx_start) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= {1'b1, tx_data};
            tx       <= 1'b0;
         end
      end else if (baud_cnt == BIT_LAST) begin
         baud_cnt <= '0;
         if (bit_cnt == 4'd9) begin
            active <= 1'b0;
            tx     <= 1'b1;
         end else begin
            tx      <= shift[0];
            shift   <= {1'b1, shift[8:1]};
            bit_cnt <= bit_cnt + 4'd1;
         end
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_dump_uart.sv
`timescale 1ns/1ps
// Debug-port memory dump: reads words 0..WORDS-1 and prints "AA:DDDDDDDD\r\n" for each over 8N1 UART.
// Build option MEM_DUMP_SKIP_ZERO_EN: words reading as zero produce no line.
module mem_dump_uart
   import mem_dump_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115_200,
   parameter int WORDS  = 256,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] rd_data,
   output logic [7:0]  rd_addr,
   output logic        rd_en,
   output logic        busy,
   output logic        done,
   output logic        uart_tx
);
   localparam logic [7:0] LAST_ADDR = 8'(WORDS - 1);
   localparam logic [1:0] LAT_LAST  = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
   localparam logic [3:0] LAST_CHAR = 4'(LINE_LEN);
   // With zero read latency the data is already valid, so RD is skipped.
   localparam state_t     FIRST_RD  = (RD_LAT > 0) ? RD : LATCH;

   state_t      state_reg, state_next;
   logic [7:0]  addr_reg, addr_next;
   logic [31:0] word_reg, word_next;
   logic [3:0]  char_reg, char_next;
   logic [1:0]  lat_reg, lat_next;
   logic [2:0]  nib_sel;
   logic        tx_start, tx_ready;
   logic [7:0]  tx_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         word_reg  <= '0;
         char_reg  <= '0;
         lat_reg   <= '0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         word_reg  <= word_next;
         char_reg  <= char_next;
         lat_reg   <= lat_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      word_next  = word_reg;
      char_next  = char_reg;
      lat_next   = lat_reg;
      tx_start   = 1'b0;
      case (state_reg)
         IDLE: if (start) begin
            addr_next  = '0;
            lat_next   = '0;
            state_next = FIRST_RD;
         end
         RD: if (lat_reg == LAT_LAST) state_next = LATCH;
             else lat_next = lat_reg + 2'd1;
         LATCH: begin
            word_next = rd_data;
            char_next = '0;
`ifdef MEM_DUMP_SKIP_ZERO_EN
            state_next = (rd_data == 32'h0) ? NEXT : SEND;
`else
            state_next = SEND;
`endif
         end
         // Leave only once the LF frame has fully left the transmitter.
         SEND: if (char_reg != LAST_CHAR) begin
            tx_start = tx_ready;
            if (tx_ready) char_next = char_reg + 4'd1;
         end else if (tx_ready) begin
            state_next = NEXT;
         end
         NEXT: if (addr_reg == LAST_ADDR) begin
            state_next = FIN;
         end else begin
            addr_next  = addr_reg + 8'd1;
            lat_next   = '0;
            state_next = FIRST_RD;
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Characters 3..10 are the data nibbles, most significant first.
   always_comb begin
      nib_sel = 3'(4'd10 - char_reg);
      tx_data = hex2ascii(word_reg[{nib_sel, 2'b00} +: 4]);
      case (char_reg)
         4'd0:    tx_data = hex2ascii(addr_reg[7:4]);
         4'd1:    tx_data = hex2ascii(addr_reg[3:0]);
         4'd2:    tx_data = COLON;
         4'd11:   tx_data = CR;
         4'd12:   tx_data = LF;
         default: ;
      endcase
   end

   assign rd_addr = addr_reg;
   assign rd_en   = (state_reg == RD) || (state_reg == LATCH);
   assign busy    = (state_reg == RD) || (state_reg == LATCH) || (state_reg == SEND) || (state_reg == NEXT);
   assign done    = (state_reg == FIN);

   uart_tx_byte #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_tx (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .tx       (uart_tx)
   );

endmodule

// File: tb/tb_mem_dump_uart.sv
`timescale 1ns/1ps
// Directed bench for mem_dump_uart: one instance with WORDS=1, one with WORDS=4; UART lines decoded at 10 clks/bit.
module tb_mem_dump_uart;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start1 = 1'b0, start4 = 1'b0;
   logic [31:0] rd_data1, rd_data4;
   logic [7:0]  rd_addr1, rd_addr4;
   logic        rd_en1, rd_en4, busy1, busy4, done1, done4, tx1, tx4;
   logic [31:0] mem1 [1];
   logic [31:0] mem4 [4];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_dump_uart #(.CLK_HZ(1_000_000), .BAUD(100_000), .WORDS(1), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .rd_data(rd_data1), .rd_addr(rd_addr1),
      .rd_en(rd_en1), .busy(busy1), .done(done1), .uart_tx(tx1));

   mem_dump_uart #(.CLK_HZ(1_000_000), .BAUD(100_000), .WORDS(4), .RD_LAT(1)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .rd_data(rd_data4), .rd_addr(rd_addr4),
      .rd_en(rd_en4), .busy(busy4), .done(done4), .uart_tx(tx4));

   // Memory model: registered read, garbage when no read is in progress.
   always @(posedge clk) begin
      rd_data1 <= rd_en1 ? mem1[0] : 32'h5A5A_5A5A;
      rd_data4 <= rd_en4 ? mem4[rd_addr4[1:0]] : 32'h5A5A_5A5A;
   end

   // UART receivers sampling mid-bit, plus done/address monitors.
   logic [7:0] rxq1[$], rxq4[$];
   int         fall1[$], fall4[$];
   logic       rx_act [2] = '{1'b0, 1'b0};
   int         rx_cnt [2] = '{0, 0};
   logic [7:0] rx_sh [2];
   int         ferr [2] = '{0, 0};
   int         done_cnt [2] = '{0, 0};
   int         done_cyc [2] = '{0, 0};
   logic       mon_on = 1'b0;
   int         busy_drop = 0;
   logic [7:0] addr_hist[$];
   logic       rd_en4_d = 1'b0;

   always @(negedge clk) begin
      logic line_v [2];
      line_v[0] = tx1;
      line_v[1] = tx4;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            rx_act[i] = 1'b0;
         end else if (!rx_act[i]) begin
            if (line_v[i] == 1'b0) begin
               rx_act[i] = 1'b1;
               rx_cnt[i] = 0;
               if (i == 0) fall1.push_back(cyc); else fall4.push_back(cyc);
            end
         end else begin
            rx_cnt[i]++;
            if (rx_cnt[i] % 10 == 5 && rx_cnt[i] > 5) begin
               if (rx_cnt[i] < 95) begin
                  rx_sh[i] = {line_v[i], rx_sh[i][7:1]};
               end else begin
                  if (line_v[i] != 1'b1) ferr[i]++;
                  if (i == 0) rxq1.push_back(rx_sh[i]); else rxq4.push_back(rx_sh[i]);
                  rx_act[i] = 1'b0;
               end
            end
         end
      end
      if (done1 === 1'b1) begin done_cnt[0]++; done_cyc[0] = cyc; end
      if (done4 === 1'b1) begin done_cnt[1]++; done_cyc[1] = cyc; end
      if (mon_on) begin
         if (busy4 !== 1'b1 && done4 !== 1'b1) busy_drop++;
         if (rd_en4 === 1'b1 && rd_en4_d !== 1'b1) addr_hist.push_back(rd_addr4);
      end
      rd_en4_d = rd_en4;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic string ln(input string body);
      return $sformatf("%s%c%c", body, 8'h0D, 8'h0A);
   endfunction

   task automatic chk_line(input string tag, input string exp, input int dut);
      int n, mis;
      logic [7:0] c;
      n = (dut == 1) ? rxq1.size() : rxq4.size();
      chk({tag, "_len"}, 64'(n), 64'(exp.len()));
      mis = -1;
      for (int k = 0; k < exp.len() && k < n; k++) begin
         c = (dut == 1) ? rxq1[k] : rxq4[k];
         if (mis < 0 && c != exp[k]) mis = k;
      end
      chk({tag, "_first_bad_idx"}, 64'(mis), 64'(-1));
   endtask

   task automatic pulse(input int dut, output int sc);
      sc = cyc;
      if (dut == 1) start1 = 1'b1; else start4 = 1'b1;
      tick();
      start1 = 1'b0;
      start4 = 1'b0;
   endtask

   task automatic wait_done(input int dut, input int limit, output int got);
      got = 0;
      for (int k = 0; k < limit; k++) begin
         tick();
         if (((dut == 1) ? done1 : done4) === 1'b1) begin
            got = 1;
            break;
         end
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tx1"}, 64'(tx1), 64'(1));
      chk({tag, "_tx4"}, 64'(tx4), 64'(1));
      chk({tag, "_busy4"}, 64'(busy4), 64'(0));
      chk({tag, "_rd_en4"}, 64'(rd_en4), 64'(0));
      chk({tag, "_rd_addr4"}, 64'(rd_addr4), 64'(0));
      chk({tag, "_done4"}, 64'(done4), 64'(0));
      chk({tag, "_busy1_rd_en1_done1_addr1"}, {52'(0), busy1, rd_en1, done1, 1'b0, rd_addr1}, 64'(0));
   endtask

   task automatic clear_rx();
      rxq1.delete(); rxq4.delete(); fall1.delete(); fall4.delete();
   endtask

   initial begin
      int sc, got, d0, g;
      string s2, s3, s6;
      s2 = ln("00:DEADBEEF");
`ifdef MEM_DUMP_SKIP_ZERO_EN
      s3 = {ln("01:00000001"), ln("02:CAFEF00D"), ln("03:FFFFFFFF")};
`else
      s3 = {ln("00:00000000"), ln("01:00000001"), ln("02:CAFEF00D"), ln("03:FFFFFFFF")};
`endif
      s6 = ln("01:00000005");
      mem1[0] = 32'hDEAD_BEEF;
      mem4 = '{32'h0, 32'h1, 32'hCAFE_F00D, 32'hFFFF_FFFF};

      // 1. reset state, then reset held in the middle of a dump
      repeat (3) tick();
      chk_reset("s1_por");
      rst = 1'b0;
      repeat (2) tick();
      pulse(4, sc);
      repeat (40) tick();
      chk("s1_busy_before_rst", 64'(busy4), 64'(1));
      rst = 1'b1;
      #1;
      chk_reset("s1_async");
      repeat (3) tick();
      chk_reset("s1_held");
      rst = 1'b0;
      repeat (3) tick();
      $display("step 1: reset checks complete at cycle %0d", cyc);

      // 2. single-word dump, timing of frames and done
      clear_rx();
      d0 = done_cnt[0];
      pulse(1, sc);
      wait_done(1, 2000, got);
      chk("s2_done_seen", 64'(got), 64'(1));
      repeat (20) tick();
      chk_line("s2_line", s2, 1);
      chk("s2_done_count", 64'(done_cnt[0] - d0), 64'(1));
      if (fall1.size() >= 13) begin
         chk("s2_start_latency", 64'(fall1[0] - sc), 64'(4));
         g = fall1[1] - fall1[0];
         chk("s2_char_spacing_ok", 64'(g == 100 || g == 101), 64'(1));
         g = done_cyc[0] - fall1[12];
         chk("s2_done_after_stop", 64'(g >= 100 && g <= 103), 64'(1));
      end else begin
         chk("s2_frame_count", 64'(fall1.size()), 64'(13));
      end
      chk("s2_busy_after", 64'(busy1), 64'(0));
      $display("step 2: dut1 dump chars=%0d", rxq1.size());

      // 3. four-word dump, address walk and busy
      clear_rx();
      addr_hist.delete();
      busy_drop = 0;
      d0 = done_cnt[1];
      mon_on = 1'b1;
      pulse(4, sc);
      wait_done(4, 7000, got);
      mon_on = 1'b0;
      chk("s3_done_seen", 64'(got), 64'(1));
      repeat (20) tick();
      chk_line("s3_line", s3, 4);
      chk("s3_done_count", 64'(done_cnt[1] - d0), 64'(1));
      chk("s3_busy_drops", 64'(busy_drop), 64'(0));
      chk("s3_addr_count", 64'(addr_hist.size()), 64'(4));
      for (int k = 0; k < 4 && k < addr_hist.size(); k++)
         chk($sformatf("s3_addr_%0d", k), 64'(addr_hist[k]), 64'(k));
      chk("s3_addr_hold", 64'(rd_addr4), 64'(3));
      $display("step 3: dut4 dump chars=%0d", rxq4.size());

      // 4. start re-pulsed mid-dump and during FIN
      clear_rx();
      d0 = done_cnt[1];
      pulse(4, sc);
      got = 0;
      for (int k = 0; k < 7000; k++) begin
         start4 = (k == 150 || k == 2000);
         tick();
         if (done4 === 1'b1) begin
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            got = 1;
            break;
         end
      end
      start4 = 1'b0;
      chk("s4_done_seen", 64'(got), 64'(1));
      repeat (40) tick();
      chk_line("s4_line", s3, 4);
      chk("s4_done_count", 64'(done_cnt[1] - d0), 64'(1));
      chk("s4_idle_after_fin_start", 64'(busy4), 64'(0));
      $display("step 4: dut4 dump with extra starts chars=%0d", rxq4.size());

      // 5. reset during a start bit in line 01, then a fresh dump
      clear_rx();
      pulse(4, sc);
      got = 0;
      for (int k = 0; k < 3000; k++) begin
         tick();
         if (fall4.size() >= 19) begin got = 1; break; end
      end
      chk("s5_reached_char", 64'(got), 64'(1));
      repeat (3) tick();
      chk("s5_tx_low_before", 64'(tx4), 64'(0));
      rst = 1'b1;
      #1;
      chk("s5_tx_high_at_once", 64'(tx4), 64'(1));
      repeat (2) tick();
      rst = 1'b0;
      tick();
      clear_rx();
      pulse(4, sc);
      wait_done(4, 7000, got);
      chk("s5_done_seen", 64'(got), 64'(1));
      repeat (20) tick();
      chk_line("s5_line", s3, 4);
      $display("step 5: dut4 dump after reset chars=%0d", rxq4.size());

`ifdef MEM_DUMP_SKIP_ZERO_EN
      // 6. zero words skipped
      mem4 = '{32'h0, 32'h5, 32'h0, 32'h0};
      clear_rx();
      pulse(4, sc);
      wait_done(4, 7000, got);
      chk("s6_done_seen", 64'(got), 64'(1));
      repeat (20) tick();
      chk_line("s6_line", s6, 4);
      mem4 = '{32'h0, 32'h0, 32'h0, 32'h0};
      clear_rx();
      pulse(4, sc);
      wait_done(4, 20, got);
      chk("s6_all_zero_done", 64'(got), 64'(1));
      repeat (20) tick();
      chk("s6_all_zero_no_frame", 64'(fall4.size()), 64'(0));
      $display("step 6: skip-zero dumps complete");
`else
      $display("step 6: skip-zero build option not enabled, line %0d chars", s6.len());
`endif

      chk("frame_errors", 64'(ferr[0] + ferr[1]), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
